vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_mem_arbiter
// Description : Single-port framebuffer RAM arbiter. The display read path
//               always wins. A 4-deep write FIFO comes next, and a frame-clear
//               engine uses the cycles that are left over.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int ADDR_W       = 19,
    parameter int STARVE_LIMIT = 800
) (
    input  logic              pixelClock,
    input  logic              reset,
    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic [23:0]       dispData,
    output logic              dispValid,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [23:0]       wrData,
    input  logic              clearStart,
    input  logic [23:0]       clearColor,
    output logic              clearBusy,
    output logic              clearDone,
    output logic [2:0]        fifoLevel,
    output logic              starved,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [23:0]       memWdata,
    input  logic [23:0]       memRdata
);

    localparam int                c_PIXELS_I = H_VISIBLE * V_VISIBLE;
    localparam logic [ADDR_W:0]   c_PIXELS   = (ADDR_W+1)'(c_PIXELS_I);
    localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(c_PIXELS_I - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam int                c_CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE  = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam int                c_ENTRY_W  = ADDR_W + 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_clearAddr;
    logic [23:0]          r_color;
    logic                 r_clearDone;

    logic [c_ENTRY_W-1:0] r_fifo [4];
    logic [1:0]           r_wrPtr;
    logic [1:0]           r_rdPtr;
    logic [2:0]           r_level;
    logic [c_CNT_W-1:0]   r_starveCnt;

    logic                 r_memEn;
    logic                 r_memWe;
    logic [ADDR_W-1:0]    r_memAddr;
    logic [23:0]          r_memWdata;

    logic                 r_dv1;
    logic                 r_dv2;
    logic                 r_dispValid;
    logic [23:0]          r_dispData;

    logic [c_ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]    w_headAddr;
    logic [23:0]          w_headData;
    logic                 w_nonEmpty;
    logic                 w_headOob;
    logic                 w_pop;
    logic                 w_grHead;
    logic                 w_grClear;
    logic                 w_wrReady;
    logic                 w_push;

    // Head decode and grant decision from this cycle's inputs and state
    assign w_head     = r_fifo[r_rdPtr];
    assign w_headAddr = w_head[c_ENTRY_W-1:24];
    assign w_headData = w_head[23:0];
    assign w_nonEmpty = (r_level != 3'd0);
    assign w_headOob  = ({1'b0, w_headAddr} >= c_PIXELS);
    // An out-of-range head is popped without a RAM access, so the clear
    // engine may use that cycle.
    assign w_pop      = !dispReq && w_nonEmpty;
    assign w_grHead   = w_pop && !w_headOob;
    assign w_grClear  = (r_state == CLEAR) && !dispReq && !w_grHead;
    assign w_wrReady  = (r_level < 3'd4) && (r_state == IDLE) && !reset;
    assign w_push     = wrValid && w_wrReady;

    // FIFO payload storage; contents need no reset because the level gates them
    always_ff @(posedge pixelClock) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= {wrAddr, wrData};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            r_level <= 3'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Starvation counter: counts denied head cycles and saturates at the limit
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else if (!w_nonEmpty || w_pop) begin
            r_starveCnt <= '0;
        end else if (r_starveCnt != c_STARVE) begin
            r_starveCnt <= r_starveCnt + c_CNT_ONE;
        end
    end

    // Registered RAM command for the winner of this cycle
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= 24'd0;
        end else begin
            r_memEn <= dispReq || w_grHead || w_grClear;
            r_memWe <= !dispReq && (w_grHead || w_grClear);
            if (dispReq) begin
                r_memAddr <= dispAddr;
            end else if (w_grHead) begin
                r_memAddr  <= w_headAddr;
                r_memWdata <= w_headData;
            end else if (w_grClear) begin
                r_memAddr  <= r_clearAddr;
                r_memWdata <= r_color;
            end
        end
    end

    // Display return pipeline: command, RAM read, then registered pixel
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_dv1       <= 1'b0;
            r_dv2       <= 1'b0;
            r_dispValid <= 1'b0;
            r_dispData  <= 24'd0;
        end else begin
            r_dv1       <= dispReq;
            r_dv2       <= r_dv1;
            r_dispValid <= r_dv2;
            if (r_dv2) begin
                r_dispData <= memRdata;
            end
        end
    end

    // Clear sequencer: wait for the FIFO to drain, then sweep every pixel
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_clearAddr <= '0;
            r_color     <= 24'd0;
            r_clearDone <= 1'b0;
        end else begin
            r_clearDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clearStart) begin
                        r_state <= DRAIN;
                        r_color <= clearColor;
                    end
                end
                DRAIN: begin
                    if (!w_nonEmpty) begin
                        r_state     <= CLEAR;
                        r_clearAddr <= '0;
                    end
                end
                CLEAR: begin
                    if (w_grClear) begin
                        if (r_clearAddr == c_LAST) begin
                            r_state     <= IDLE;
                            r_clearDone <= 1'b1;
                        end else begin
                            r_clearAddr <= r_clearAddr + c_ADDR_ONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dispData  = r_dispData;
    assign dispValid = r_dispValid;
    assign wrReady   = w_wrReady;
    assign clearBusy = (r_state != IDLE);
    assign clearDone = r_clearDone;
    assign fifoLevel = r_level;
    assign starved   = (r_starveCnt == c_STARVE);
    assign memEn     = r_memEn;
    assign memWe     = r_memWe;
    assign memAddr   = r_memAddr;
    assign memWdata  = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mem_arbiter
// Description : Directed self-checking bench for vga_mem_arbiter. The frame is
//               shrunk to 16x8 pixels so a full clear sweep stays short; the
//               out-of-range address is therefore 128 and the mid-clear reset
//               point is address 50.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

    localparam int c_H      = 16;
    localparam int c_V      = 8;
    localparam int c_AW     = 19;
    localparam int c_STARVE = 800;
    localparam int c_PIX    = c_H * c_V;

    logic            pixelClock = 1'b0;
    logic            reset      = 1'b1;
    logic            dispReq    = 1'b0;
    logic [c_AW-1:0] dispAddr   = '0;
    logic [23:0]     dispData;
    logic            dispValid;
    logic            wrValid    = 1'b0;
    logic            wrReady;
    logic [c_AW-1:0] wrAddr     = '0;
    logic [23:0]     wrData     = '0;
    logic            clearStart = 1'b0;
    logic [23:0]     clearColor = '0;
    logic            clearBusy;
    logic            clearDone;
    logic [2:0]      fifoLevel;
    logic            starved;
    logic            memEn;
    logic            memWe;
    logic [c_AW-1:0] memAddr;
    logic [23:0]     memWdata;
    logic [23:0]     memRdata   = '0;

    int errors = 0;
    int checks = 0;

    vga_mem_arbiter #(
        .H_VISIBLE   (c_H),
        .V_VISIBLE   (c_V),
        .ADDR_W      (c_AW),
        .STARVE_LIMIT(c_STARVE)
    ) dut (
        .pixelClock(pixelClock),
        .reset     (reset),
        .dispReq   (dispReq),
        .dispAddr  (dispAddr),
        .dispData  (dispData),
        .dispValid (dispValid),
        .wrValid   (wrValid),
        .wrReady   (wrReady),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .clearStart(clearStart),
        .clearColor(clearColor),
        .clearBusy (clearBusy),
        .clearDone (clearDone),
        .fifoLevel (fifoLevel),
        .starved   (starved),
        .memEn     (memEn),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWdata  (memWdata),
        .memRdata  (memRdata)
    );

    always #5 pixelClock = ~pixelClock;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge pixelClock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wrValid = 1'b1; dispReq = 1'b1; clearStart = 1'b1;
        repeat (3) tick();
        checks++; if (memEn !== 1'b0) begin errors++; $display("FAIL reset_memEn: got %b want 0", memEn); end
        checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL reset_memWe: got %b want 0", memWe); end
        checks++; if (dispValid !== 1'b0) begin errors++; $display("FAIL reset_dispValid: got %b want 0", dispValid); end
        checks++; if (fifoLevel !== 3'd0) begin errors++; $display("FAIL reset_fifoLevel: got %0d want 0", fifoLevel); end
        checks++; if (clearBusy !== 1'b0) begin errors++; $display("FAIL reset_clearBusy: got %b want 0", clearBusy); end
        checks++; if (clearDone !== 1'b0) begin errors++; $display("FAIL reset_clearDone: got %b want 0", clearDone); end
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL reset_starved: got %b want 0", starved); end
        checks++; if (wrReady !== 1'b0) begin errors++; $display("FAIL reset_wrReady: got %b want 0", wrReady); end
        wrValid = 1'b0; dispReq = 1'b0; clearStart = 1'b0; reset = 1'b0;
        tick();
        checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL post_reset_wrReady: got %b want 1", wrReady); end
        checks++; if (memEn !== 1'b0) begin errors++; $display("FAIL post_reset_memEn: got %b want 0", memEn); end
    endtask

    task automatic test_display();
        logic [23:0] exp_d [3];
        exp_d[0] = 24'h102030; exp_d[1] = 24'h405060; exp_d[2] = 24'h708090;
        dispReq = 1'b1; dispAddr = 19'd5;
        tick();
        dispReq = 1'b0;
        checks++; if (memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 19'd5) begin
            errors++; $display("FAIL disp_cmd: got en=%b we=%b addr=%0d want en=1 we=0 addr=5", memEn, memWe, memAddr);
        end
        checks++; if (dispValid !== 1'b0) begin errors++; $display("FAIL disp_early: got %b want 0", dispValid); end
        tick();
        memRdata = 24'hFF00FF;
        tick();
        memRdata = 24'h000000;
        checks++; if (dispValid !== 1'b1 || dispData !== 24'hFF00FF) begin
            errors++; $display("FAIL disp_latency3: got valid=%b data=%h want valid=1 data=ff00ff", dispValid, dispData);
        end
        tick();
        checks++; if (dispValid !== 1'b0) begin errors++; $display("FAIL disp_single: got %b want 0", dispValid); end
        for (int k = 0; k < 7; k++) begin
            dispReq  = (k < 3);
            dispAddr = 19'(k + 1);
            memRdata = 24'h0;
            if (k >= 2 && k < 5) memRdata = exp_d[k-2];
            checks++;
            if (k >= 3 && k < 6) begin
                if (dispValid !== 1'b1 || dispData !== exp_d[k-3]) begin
                    errors++; $display("FAIL disp_b2b[%0d]: got valid=%b data=%h want valid=1 data=%h", k, dispValid, dispData, exp_d[k-3]);
                end
            end else if (dispValid !== 1'b0) begin
                errors++; $display("FAIL disp_b2b_idle[%0d]: got %b want 0", k, dispValid);
            end
            tick();
        end
        dispReq = 1'b0; memRdata = 24'h0;
    endtask

    // Display traffic holds the head so the FIFO can fill; dropping it drains.
    task automatic test_fifo_full();
        logic [c_AW-1:0] wa [$];
        logic [23:0]     wd [$];
        bit              order_ok;
        dispReq = 1'b1; dispAddr = 19'd7; wrValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wrAddr = 19'(10 + i); wrData = 24'hA00000 + 24'(i);
            checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, wrReady); end
            tick();
        end
        wrAddr = 19'd14; wrData = 24'hA00004;
        checks++; if (fifoLevel !== 3'd4 || wrReady !== 1'b0) begin
            errors++; $display("FAIL full_state: got level=%0d ready=%b want level=4 ready=0", fifoLevel, wrReady);
        end
        checks++; if (memWe !== 1'b0) begin errors++; $display("FAIL full_no_write: got we=%b want 0", memWe); end
        tick();
        checks++; if (wrReady !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", wrReady); end
        dispReq = 1'b0;
        tick();
        checks++; if (fifoLevel !== 3'd3 || wrReady !== 1'b1) begin
            errors++; $display("FAIL first_free: got level=%0d ready=%b want level=3 ready=1", fifoLevel, wrReady);
        end
        for (int n = 0; n < 8; n++) begin
            if (n == 1) wrValid = 1'b0;
            if (memEn === 1'b1 && memWe === 1'b1) begin
                wa.push_back(memAddr); wd.push_back(memWdata);
            end
            tick();
        end
        order_ok = (wa.size() == 5);
        for (int i = 0; i < wa.size() && i < 5; i++) begin
            if (wa[i] !== 19'(10 + i) || wd[i] !== 24'hA00000 + 24'(i)) order_ok = 1'b0;
        end
        checks++; if (!order_ok) begin errors++; $display("FAIL fifo_order: got %0d writes (first addr %0d) want 5 writes addr 10..14", wa.size(), (wa.size() > 0) ? wa[0] : 19'd0); end
        checks++; if (fifoLevel !== 3'd0) begin errors++; $display("FAIL fifo_empty: got %0d want 0", fifoLevel); end
    endtask

    task automatic test_oob();
        dispReq = 1'b0; wrValid = 1'b1; wrAddr = 19'(c_PIX); wrData = 24'h000055;
        tick();
        wrValid = 1'b0;
        checks++; if (fifoLevel !== 3'd1) begin errors++; $display("FAIL oob_pushed: got %0d want 1", fifoLevel); end
        tick();
        checks++; if (memEn !== 1'b0 || fifoLevel !== 3'd0) begin
            errors++; $display("FAIL oob_discard: got en=%b level=%0d want en=0 level=0", memEn, fifoLevel);
        end
        tick();
        checks++; if (memEn !== 1'b0) begin errors++; $display("FAIL oob_no_access: got %b want 0", memEn); end
    endtask

    task automatic test_starve();
        dispReq = 1'b1; dispAddr = 19'd3; wrValid = 1'b1; wrAddr = 19'd20; wrData = 24'h5A5A5A;
        tick();
        wrValid = 1'b0;
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_start: got %b want 0", starved); end
        repeat (799) tick();
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_799: got %b want 0", starved); end
        tick();
        checks++; if (starved !== 1'b1 || fifoLevel !== 3'd1) begin
            errors++; $display("FAIL starve_800: got starved=%b level=%0d want starved=1 level=1", starved, fifoLevel);
        end
        tick();
        checks++; if (starved !== 1'b1) begin errors++; $display("FAIL starve_sat: got %b want 1", starved); end
        dispReq = 1'b0;
        tick();
        checks++; if (starved !== 1'b0 || memEn !== 1'b1 || memWe !== 1'b1 || memAddr !== 19'd20 || memWdata !== 24'h5A5A5A) begin
            errors++; $display("FAIL starve_release: got starved=%b en=%b we=%b addr=%0d data=%h want 0 1 1 20 5a5a5a", starved, memEn, memWe, memAddr, memWdata);
        end
    endtask

    task automatic test_clear();
        logic [c_AW-1:0] wa [$];
        logic [23:0]     wd [$];
        int  done_cnt = 0;
        int  done_n   = -1;
        bit  busy_at_done  = 1'b1;
        bit  ready_at_done = 1'b0;
        bit  seq_ok;
        dispReq = 1'b1; dispAddr = 19'd1; wrValid = 1'b1; wrAddr = 19'd30; wrData = 24'hC0FFEE;
        tick();
        wrAddr = 19'd31; wrData = 24'hBEEF01;
        tick();
        wrValid = 1'b0; clearStart = 1'b1; clearColor = 24'h123456;
        checks++; if (fifoLevel !== 3'd2) begin errors++; $display("FAIL clear_pending: got %0d want 2", fifoLevel); end
        tick();
        clearStart = 1'b0; clearColor = 24'h000000; dispReq = 1'b0;
        checks++; if (clearBusy !== 1'b1 || wrReady !== 1'b0) begin
            errors++; $display("FAIL clear_busy: got busy=%b ready=%b want busy=1 ready=0", clearBusy, wrReady);
        end
        for (int n = 0; n < 300; n++) begin
            clearStart = (n == 10);
            clearColor = (n == 10) ? 24'hABCDEF : 24'h000000;
            dispReq    = (n == 40);
            if (memEn === 1'b1 && memWe === 1'b1) begin
                wa.push_back(memAddr); wd.push_back(memWdata);
            end
            if (clearDone === 1'b1) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n = n; busy_at_done = clearBusy; ready_at_done = wrReady;
                end
            end
            if (done_n >= 0 && n >= done_n + 3) break;
            tick();
        end
        clearStart = 1'b0; dispReq = 1'b0;
        seq_ok = (wa.size() == c_PIX + 2);
        if (seq_ok) begin
            if (wa[0] !== 19'd30 || wd[0] !== 24'hC0FFEE || wa[1] !== 19'd31 || wd[1] !== 24'hBEEF01) seq_ok = 1'b0;
            for (int j = 0; j < c_PIX; j++) begin
                if (wa[j+2] !== 19'(j) || wd[j+2] !== 24'h123456) seq_ok = 1'b0;
            end
        end
        checks++; if (!seq_ok) begin errors++; $display("FAIL clear_sequence: got %0d writes want %0d (2 fifo then 0..%0d of 123456)", wa.size(), c_PIX + 2, c_PIX - 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clear_done_pulse: got %0d pulses want 1", done_cnt); end
        checks++; if (busy_at_done !== 1'b0 || ready_at_done !== 1'b1) begin
            errors++; $display("FAIL clear_end_state: got busy=%b ready=%b want busy=0 ready=1", busy_at_done, ready_at_done);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit found = 1'b0;
        dispReq = 1'b0; clearStart = 1'b1; clearColor = 24'h0F0F0F;
        tick();
        clearStart = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (memEn === 1'b1 && memWe === 1'b1 && memAddr === 19'd50) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL midclear_reach: got no write to 50 want write to 50"); end
        dispReq = 1'b1; dispAddr = 19'd9;
        tick();
        dispReq = 1'b0; reset = 1'b1;
        tick();
        checks++; if (clearBusy !== 1'b0 || clearDone !== 1'b0 || fifoLevel !== 3'd0 || memEn !== 1'b0 || wrReady !== 1'b0) begin
            errors++; $display("FAIL midclear_reset: got busy=%b done=%b level=%0d en=%b ready=%b want all 0", clearBusy, clearDone, fifoLevel, memEn, wrReady);
        end
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++; if (dispValid !== 1'b0 || clearDone !== 1'b0 || memEn !== 1'b0 || clearBusy !== 1'b0) begin
                errors++; $display("FAIL midclear_quiet[%0d]: got valid=%b done=%b en=%b busy=%b want all 0", n, dispValid, clearDone, memEn, clearBusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_fifo_full();
        test_oob();
        test_starve();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
